// File: rtl/imem_loader.sv
// imem_loader: length-prefixed byte-stream loader that fills instruction memory and stalls the CPU until done.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_WORDS = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte_data,
  output logic        o_byte_ready,
  output logic        o_imem_we,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic        o_cpu_hold,
  output logic        o_load_done,
  output logic        o_load_err
);
  localparam logic [2:0] S_LEN_HI = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;
  logic [2:0]  r_state;
  logic [15:0] r_len;
  logic [15:0] r_wcnt;
  logic [1:0]  r_bcnt;
  logic [31:0] r_wdata;
  logic [31:0] r_addr;
  logic        w_xfer;
  logic [15:0] w_len;
  assign o_byte_ready = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) || (r_state == S_DATA);
  assign o_imem_we    = r_state == S_WRITE;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_cpu_hold   = r_state != S_DONE;
  assign o_load_done  = r_state == S_DONE;
  assign o_load_err   = r_state == S_ERR;
  assign w_xfer       = i_byte_valid && o_byte_ready;
  assign w_len        = {r_len[15:8], i_byte_data};
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_LEN_HI;
      r_len   <= '0;
      r_wcnt  <= '0;
      r_bcnt  <= '0;
      r_wdata <= '0;
      r_addr  <= BASE_ADDR;
    end else begin
      case (r_state)
        S_LEN_HI: if (w_xfer) begin
          r_len[15:8] <= i_byte_data;
          r_state     <= S_LEN_LO;
        end
        S_LEN_LO: if (w_xfer) begin
          r_len[7:0] <= i_byte_data;
          r_state    <= (w_len == 16'd0) ? S_DONE : (w_len > 16'(MAX_WORDS)) ? S_ERR : S_DATA;
        end
        S_DATA: if (w_xfer) begin
          r_wdata <= {r_wdata[23:0], i_byte_data};
          r_bcnt  <= r_bcnt + 2'd1;
          if (r_bcnt == 2'd3) r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_addr  <= r_addr + 32'd4;
          r_wcnt  <= r_wcnt + 16'd1;
          r_state <= (r_wcnt + 16'd1 == r_len) ? S_DONE : S_DATA;
        end
        default: r_state <= r_state;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed streams checked against a stream-level model of the expected memory writes.
module tb_imem_loader;
  localparam int PER = 10;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  data = 8'd0;
  logic        byte_ready, imem_we, cpu_hold, load_done, load_err;
  logic [31:0] imem_addr, imem_wdata;
  int          vectors = 0;
  int          errors = 0;
  logic [7:0]  stim[$];
  logic [63:0] exp_q[$];
  bit          exp_done, exp_err;
  int          exp_acc, n_acc, n_writes;
  logic [31:0] last_addr, last_wdata;
  time         t_first, t_done;

  imem_loader #(.BASE_ADDR(32'd0), .MAX_WORDS(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_byte_valid(valid), .i_byte_data(data),
    .o_byte_ready(byte_ready), .o_imem_we(imem_we), .o_imem_addr(imem_addr),
    .o_imem_wdata(imem_wdata), .o_cpu_hold(cpu_hold), .o_load_done(load_done),
    .o_load_err(load_err)
  );

  always #(PER/2) clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    logic [63:0] e;
    check("done_err_exclusive", {31'd0, load_done & load_err}, 32'd0);
    check("hold_only_released_in_done", {31'd0, cpu_hold}, {31'd0, !load_done});
    if (imem_we) begin
      check("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
      n_writes++;
      last_addr  = imem_addr;
      last_wdata = imem_wdata;
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h, no write required", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", imem_addr, e[63:32]);
        check("write_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic build_model();
    int n;
    exp_q.delete();
    n = int'({stim[0], stim[1]});
    exp_err  = n > 64;
    exp_done = !exp_err && (stim.size() >= 2 + 4 * n);
    exp_acc  = (exp_err || n == 0) ? 2 : ((stim.size() < 2 + 4 * n) ? stim.size() : 2 + 4 * n);
    if (!exp_err)
      for (int i = 0; i < n; i++)
        if (2 + 4 * i + 4 <= stim.size())
          exp_q.push_back({32'(4 * i), stim[2+4*i], stim[3+4*i], stim[4+4*i], stim[5+4*i]});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", {31'd0, byte_ready}, 32'd1);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_done_err", {30'd0, load_done, load_err}, 32'd0);
    exp_q.delete();
    n_writes = 0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic drive(input bit toggle, input int max_cyc);
    int idx = 0;
    bit ph = 1'b1;
    for (int c = 0; c < max_cyc && idx < stim.size(); c++) begin
      @(negedge clk);
      valid = toggle ? ph : 1'b1;
      ph = ~ph;
      data = stim[idx];
      if (valid && byte_ready) begin
        if (idx == 2) t_first = $time;
        idx++;
      end
    end
    @(negedge clk) valid = 1'b0;
    n_acc = idx;
  endtask

  task automatic finish_check(input string name);
    for (int c = 0; c < 30 && !(load_done || load_err); c++) @(negedge clk);
    t_done = $time;
    repeat (3) @(negedge clk);
    check({name, "_done"}, {31'd0, load_done}, {31'd0, exp_done});
    check({name, "_err"}, {31'd0, load_err}, {31'd0, exp_err});
    check({name, "_hold"}, {31'd0, cpu_hold}, {31'd0, !exp_done});
    check({name, "_ready"}, {31'd0, byte_ready}, 32'd0);
    check({name, "_accepted"}, n_acc, exp_acc);
    check({name, "_writes_left"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    do_reset();
    stim = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05};
    build_model();
    drive(1'b0, 40);
    finish_check("one_word");
    check("one_word_n", n_writes, 32'd1);
    check("one_word_addr", last_addr, 32'd0);
    check("one_word_data", last_wdata, 32'h20080005);

    do_reset();
    stim = '{8'h00, 8'h03, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
             8'h33, 8'h33, 8'h33, 8'h33};
    build_model();
    drive(1'b0, 60);
    finish_check("three_words");
    check("three_words_cycles", 32'((t_done - t_first) / PER), 32'd15);
    check("three_words_n", n_writes, 32'd3);
    check("three_words_last_addr", last_addr, 32'd8);
    check("three_words_last_data", last_wdata, 32'h33333333);

    do_reset();
    stim = '{8'h00, 8'h00, 8'h12, 8'h34};
    build_model();
    drive(1'b0, 12);
    finish_check("zero_len");
    check("zero_len_n", n_writes, 32'd0);

    do_reset();
    stim = '{8'h00, 8'h41, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    build_model();
    drive(1'b0, 12);
    finish_check("too_long");
    check("too_long_n", n_writes, 32'd0);

    do_reset();
    stim = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    build_model();
    drive(1'b1, 80);
    finish_check("toggled");
    check("toggled_n", n_writes, 32'd2);
    check("toggled_last_addr", last_addr, 32'd4);
    check("toggled_last_data", last_wdata, 32'h01234567);

    do_reset();
    stim = '{8'h00, 8'h02, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    build_model();
    drive(1'b0, 40);
    repeat (3) @(negedge clk);
    check("partial_accepted", n_acc, exp_acc);
    check("partial_writes_left", exp_q.size(), 32'd0);
    check("partial_n", n_writes, 32'd1);
    check("partial_still_hold", {31'd0, cpu_hold}, 32'd1);
    do_reset();
    stim = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    build_model();
    drive(1'b0, 40);
    finish_check("reload");
    check("reload_addr", last_addr, 32'd0);
    check("reload_data", last_wdata, 32'hAABBCCDD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader that writes the instruction memory, which the single-cycle MIPS core (pc_b / instruction_memory) reads.
- Receives a length-prefixed byte stream over a valid/ready handshake.
- Assembles big-endian 32-bit words and issues one write per word to the instruction-memory write port.
- Holds the CPU in stall until the whole program is written; the testbench and the board-level host both use it to load programs before execution.

Parameters:
- BASE_ADDR, 32'd0, byte address of the first instruction written; matches the PC reset value.
- MAX_WORDS, 64, instruction-memory depth in words; larger length headers are rejected.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- byte_valid  input  1  host presents byte_data this cycle.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts byte; a transfer occurs when byte_valid && byte_ready at a rising edge.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  32  byte address of the write, word aligned.
- imem_wdata  output  32  assembled instruction word.
- cpu_hold  output  1  stalls PC/regfile/data-memory writes while 1.
- load_done  output  1  program loaded; CPU may run.
- load_err  output  1  header rejected.

Behaviour:
- Reset (async, rst_n=0), all outputs:
  - State is LEN_HI; byte_ready=1, cpu_hold=1.
  - imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0.
  - load_done=0, load_err=0.
  - Word counter and byte counter are 0.
- Stream format: 2-byte word count N (high byte first), followed by 4·N instruction bytes; each word is sent MSB first.
- States: LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
- LEN_HI: on transfer, latch N[15:8] and go to LEN_LO.
- LEN_LO: on transfer, latch N[7:0], then:
  - N==0: go to DONE.
  - N>MAX_WORDS: go to ERR.
  - Otherwise: go to DATA.
- DATA: on each transfer, shift the byte into the word register as wdata = {wdata[23:0], byte}.
  - After the 4th byte, go to WRITE; byte_ready stays 1 in DATA.
- WRITE: exactly one cycle.
  - imem_we=1 with imem_addr and imem_wdata stable; byte_ready=0, so no byte is accepted.
  - Next edge: imem_addr += 4 and word count increments. If count now equals N, go to DONE; else go to DATA.
- Throughput: maximum 4 bytes + 1 write cycle = 5 cycles per word. byte_valid low simply stalls the current state.
- DONE: cpu_hold=0, load_done=1, byte_ready=0, imem_we=0.
  - Further bytes are ignored (not accepted).
  - The state is held until reset.
- ERR: load_err=1, cpu_hold=1, byte_ready=0. The state is held until reset, and no memory write ever occurs.
- imem_addr is never written outside BASE_ADDR .. BASE_ADDR+4·(MAX_WORDS−1).
- Address arithmetic is 32-bit unsigned; no wrap is reachable given the MAX_WORDS check.
- Reset mid-load: loading aborts immediately and everything returns to reset values. Words already written remain in memory; a reload restarts at BASE_ADDR.
- load_done and load_err are never 1 simultaneously. cpu_hold is 0 only in DONE.
- imem_we is asserted only in WRITE.

Test Plan:
- Reset then stream 00 01 20 08 00 05 → one imem_we pulse, addr=0, wdata=32'h20080005; then load_done=1, cpu_hold=0, byte_ready=0.
- N=3 with back-to-back valid, words 11111111, 22222222, 33333333 → writes at addr 0, 4, 8 with those data; 15 cycles from first data byte to DONE; byte_ready=0 during each WRITE cycle.
- Header 00 00 → DONE two transfers after reset; no imem_we; load_done=1.
- Header 00 41 (65 > 64) → load_err=1, cpu_hold=1, byte_ready=0; following bytes ignored; imem_we never asserted.
- byte_valid toggling 1/0 every cycle during N=2 → same data/addresses as the continuous case; no dropped or duplicated bytes.
- rst_n pulsed low after 6 data bytes of N=2 → outputs reset immediately; a fresh stream 00 01 AA BB CC DD writes AABBCCDD at addr 0.
